// File: rtl/vga_sync_gen_if.sv
// ============================================================================
//  Module      : vga_sync_gen_if
//  Description : Configuration strobe/parameters and timing outputs of the
//                VGA sync generator, bundled with master/slave views.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface vga_sync_gen_if #(
  parameter int PULSE_WIDTH     = 8,
  parameter int REZ_MAX_WIDTH   = 11,
  parameter int HL_MARGIN_WIDTH = 8,
  parameter int HR_MARGIN_WIDTH = 8,
  parameter int VL_MARGIN_WIDTH = 8,
  parameter int VR_MARGIN_WIDTH = 8
) ();
  logic                       Load_config;
  logic [PULSE_WIDTH-1:0]     H_sync_pulse;
  logic [PULSE_WIDTH-1:0]     V_sync_pulse;
  logic [REZ_MAX_WIDTH-1:0]   H_count_max;
  logic [REZ_MAX_WIDTH-1:0]   V_count_max;
  logic [HL_MARGIN_WIDTH-1:0] H_left_margin;
  logic [HR_MARGIN_WIDTH-1:0] H_right_margin;
  logic [VL_MARGIN_WIDTH-1:0] V_left_margin;
  logic [VR_MARGIN_WIDTH-1:0] V_right_margin;

  logic                       H_sync;
  logic                       V_sync;
  logic                       Video_on;
  logic [REZ_MAX_WIDTH-1:0]   Pixel_x;
  logic [REZ_MAX_WIDTH-1:0]   Pixel_y;
  logic                       Frame_start;
  logic                       Cfg_applied;
  logic                       Cfg_error;

  modport master (
    output Load_config, H_sync_pulse, V_sync_pulse, H_count_max, V_count_max,
           H_left_margin, H_right_margin, V_left_margin, V_right_margin,
    input  H_sync, V_sync, Video_on, Pixel_x, Pixel_y, Frame_start,
           Cfg_applied, Cfg_error
  );

  modport slave (
    input  Load_config, H_sync_pulse, V_sync_pulse, H_count_max, V_count_max,
           H_left_margin, H_right_margin, V_left_margin, V_right_margin,
    output H_sync, V_sync, Video_on, Pixel_x, Pixel_y, Frame_start,
           Cfg_applied, Cfg_error
  );
endinterface

`default_nettype wire

// File: rtl/vga_sync_gen.sv
// ============================================================================
//  Module      : vga_sync_gen
//  Description : Programmable H/V sync, video-enable and pixel-coordinate
//                generator; new timing is swapped in only at frame boundaries.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_sync_gen #(
  parameter int PULSE_WIDTH     = 8,
  parameter int REZ_MAX_WIDTH   = 11,
  parameter int HL_MARGIN_WIDTH = 8,
  parameter int HR_MARGIN_WIDTH = 8,
  parameter int VL_MARGIN_WIDTH = 8,
  parameter int VR_MARGIN_WIDTH = 8,
  parameter int SYNC_ACTIVE_LOW = 1
) (
  input  wire logic     Clk,
  input  wire logic     Rst,
  vga_sync_gen_if.slave bus
);

  typedef logic [REZ_MAX_WIDTH-1:0] coord_t;
  typedef logic [REZ_MAX_WIDTH:0]   wide_t;

  typedef struct packed {
    coord_t                     hmax;
    coord_t                     vmax;
    logic [PULSE_WIDTH-1:0]     hs;
    logic [PULSE_WIDTH-1:0]     vs;
    logic [HL_MARGIN_WIDTH-1:0] hl;
    logic [HR_MARGIN_WIDTH-1:0] hr;
    logic [VL_MARGIN_WIDTH-1:0] vl;
    logic [VR_MARGIN_WIDTH-1:0] vr;
  } cfg_t;

  localparam logic [0:0] S_IDLE     = 1'b0;
  localparam logic [0:0] S_RUN      = 1'b1;
  localparam coord_t     c_ONE      = coord_t'(1);
  localparam wide_t      c_TWO      = wide_t'(2);
  localparam logic       c_SYNC_OFF = (SYNC_ACTIVE_LOW != 0);
  localparam logic       c_SYNC_ON  = (SYNC_ACTIVE_LOW == 0);

  logic [0:0] r_state;
  coord_t     r_h, r_v;
  logic       r_pend;
  cfg_t       r_act, r_stg;

  logic       r_hsync, r_vsync, r_video, r_fs, r_applied, r_error;
  coord_t     r_px, r_py;

  cfg_t   w_in;
  wide_t  w_h_sum, w_v_sum, w_hl0, w_vl0;
  logic   w_cfg_ok, w_load_ok, w_h_end, w_v_end, w_eof;
  logic   w_h_vis, w_v_vis, w_hs_on, w_vs_on;

  assign w_in = '{hmax: bus.H_count_max,   vmax: bus.V_count_max,
                  hs:   bus.H_sync_pulse,  vs:   bus.V_sync_pulse,
                  hl:   bus.H_left_margin, hr:   bus.H_right_margin,
                  vl:   bus.V_left_margin, vr:   bus.V_right_margin};

  // Sums are one bit wider than the counters so large porches cannot wrap.
  assign w_h_sum   = wide_t'(w_in.hs) + wide_t'(w_in.hl) + wide_t'(w_in.hr);
  assign w_v_sum   = wide_t'(w_in.vs) + wide_t'(w_in.vl) + wide_t'(w_in.vr);
  assign w_cfg_ok  = (w_h_sum < wide_t'(w_in.hmax)) && (w_v_sum < wide_t'(w_in.vmax)) &&
                     (wide_t'(w_in.hmax) >= c_TWO) && (wide_t'(w_in.vmax) >= c_TWO);
  assign w_load_ok = bus.Load_config & w_cfg_ok;

  assign w_h_end = (r_h == r_act.hmax - c_ONE);
  assign w_v_end = (r_v == r_act.vmax - c_ONE);
  assign w_eof   = w_h_end & w_v_end;

  assign w_hl0   = wide_t'(r_act.hs) + wide_t'(r_act.hl);
  assign w_vl0   = wide_t'(r_act.vs) + wide_t'(r_act.vl);
  assign w_h_vis = (wide_t'(r_h) >= w_hl0) &&
                   (wide_t'(r_h) + wide_t'(r_act.hr) < wide_t'(r_act.hmax));
  assign w_v_vis = (wide_t'(r_v) >= w_vl0) &&
                   (wide_t'(r_v) + wide_t'(r_act.vr) < wide_t'(r_act.vmax));
  assign w_hs_on = wide_t'(r_h) < wide_t'(r_act.hs);
  assign w_vs_on = wide_t'(r_v) < wide_t'(r_act.vs);

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state   <= S_IDLE;
      r_h       <= '0;
      r_v       <= '0;
      r_pend    <= 1'b0;
      r_act     <= '0;
      r_stg     <= '0;
      r_applied <= 1'b0;
      r_error   <= 1'b0;
    end else begin
      r_error   <= bus.Load_config & ~w_cfg_ok;
      r_applied <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_load_ok) begin
            r_act     <= w_in;
            r_state   <= S_RUN;
            r_h       <= '0;
            r_v       <= '0;
            r_applied <= 1'b1;
          end
        end
        default: begin
          if (w_eof) begin
            r_h <= '0;
            r_v <= '0;
            // A load landing on the wrap cycle beats anything already staged.
            if (w_load_ok) begin
              r_act     <= w_in;
              r_pend    <= 1'b0;
              r_applied <= 1'b1;
            end else if (r_pend) begin
              r_act     <= r_stg;
              r_pend    <= 1'b0;
              r_applied <= 1'b1;
            end
          end else begin
            if (w_load_ok) begin
              r_stg  <= w_in;
              r_pend <= 1'b1;
            end
            if (w_h_end) begin
              r_h <= '0;
              r_v <= r_v + c_ONE;
            end else begin
              r_h <= r_h + c_ONE;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst || r_state == S_IDLE) begin
      r_hsync <= c_SYNC_OFF;
      r_vsync <= c_SYNC_OFF;
      r_video <= 1'b0;
      r_px    <= '0;
      r_py    <= '0;
      r_fs    <= 1'b0;
    end else begin
      r_hsync <= w_hs_on ? c_SYNC_ON : c_SYNC_OFF;
      r_vsync <= w_vs_on ? c_SYNC_ON : c_SYNC_OFF;
      r_video <= w_h_vis & w_v_vis;
      r_px    <= (w_h_vis & w_v_vis) ? coord_t'(wide_t'(r_h) - w_hl0) : '0;
      r_py    <= (w_h_vis & w_v_vis) ? coord_t'(wide_t'(r_v) - w_vl0) : '0;
      r_fs    <= (r_h == '0) && (r_v == '0);
    end
  end

  assign bus.H_sync      = r_hsync;
  assign bus.V_sync      = r_vsync;
  assign bus.Video_on    = r_video;
  assign bus.Pixel_x     = r_px;
  assign bus.Pixel_y     = r_py;
  assign bus.Frame_start = r_fs;
  assign bus.Cfg_applied = r_applied;
  assign bus.Cfg_error   = r_error;

endmodule

`default_nettype wire

// File: tb/tb_vga_sync_gen.sv
// ============================================================================
//  Module      : tb_vga_sync_gen
//  Description : Scoreboard bench for vga_sync_gen: a timing model predicts
//                every registered output one clock ahead.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vga_sync_gen;

  typedef struct { int hmax, hs, hl, hr, vmax, vs, vl, vr; } cfg_t;
  typedef logic [27:0] obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vga_sync_gen_if bus ();

  vga_sync_gen dut (
    .Clk (clk),
    .Rst (rst),
    .bus (bus)
  );

  int    n_tests = 0;
  int    n_fail  = 0;
  string phase   = "reset";
  obs_t  exp_q[$];

  cfg_t  m_act, m_stg;
  bit    m_pend = 1'b0;
  bit    m_run  = 1'b0;
  int    m_h    = 0;
  int    m_v    = 0;

  int    cyc = 0;
  int    n_applied, n_err, n_fs, n_hlow, n_vid, last_fs, period;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic obs_t pack(bit hs, bit vs, bit vid, int px, int py, bit fs, bit ap, bit er);
    return {hs, vs, vid, 11'(px), 11'(py), fs, ap, er};
  endfunction

  function automatic cfg_t in_cfg();
    cfg_t c;
    c.hmax = int'(bus.H_count_max);   c.vmax = int'(bus.V_count_max);
    c.hs   = int'(bus.H_sync_pulse);  c.vs   = int'(bus.V_sync_pulse);
    c.hl   = int'(bus.H_left_margin); c.hr   = int'(bus.H_right_margin);
    c.vl   = int'(bus.V_left_margin); c.vr   = int'(bus.V_right_margin);
    return c;
  endfunction

  function automatic bit cfg_ok(cfg_t c);
    return (c.hs + c.hl + c.hr < c.hmax) && (c.vs + c.vl + c.vr < c.vmax) &&
           (c.hmax >= 2) && (c.vmax >= 2);
  endfunction

  function automatic bit at_eof();
    return m_run && (m_h == m_act.hmax - 1) && (m_v == m_act.vmax - 1);
  endfunction

  // Expected outputs after the coming edge, from the pre-edge model state.
  function automatic obs_t model_expect();
    bit ok, ap, er, vid, hsy, vsy, fs;
    int px, py, hstart, vstart;
    if (rst) return pack(1'b1, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    ok = bus.Load_config && cfg_ok(in_cfg());
    er = bus.Load_config && !ok;
    ap = (ok && !m_run) || (at_eof() && (m_pend || ok));
    if (!m_run) return pack(1'b1, 1'b1, 1'b0, 0, 0, 1'b0, ap, er);
    hstart = m_act.hs + m_act.hl;
    vstart = m_act.vs + m_act.vl;
    hsy = !(m_h < m_act.hs);
    vsy = !(m_v < m_act.vs);
    vid = (m_h >= hstart) && (m_h < m_act.hmax - m_act.hr) &&
          (m_v >= vstart) && (m_v < m_act.vmax - m_act.vr);
    px  = vid ? m_h - hstart : 0;
    py  = vid ? m_v - vstart : 0;
    fs  = (m_h == 0) && (m_v == 0);
    return pack(hsy, vsy, vid, px, py, fs, ap, er);
  endfunction

  task automatic model_update();
    cfg_t c;
    bit   ok;
    c  = in_cfg();
    ok = bus.Load_config && cfg_ok(c);
    if (rst) begin
      m_run = 1'b0; m_pend = 1'b0; m_h = 0; m_v = 0;
    end else if (!m_run) begin
      if (ok) begin m_act = c; m_run = 1'b1; m_h = 0; m_v = 0; end
    end else if (at_eof()) begin
      m_h = 0; m_v = 0;
      if (ok) begin m_act = c; m_pend = 1'b0; end
      else if (m_pend) begin m_act = m_stg; m_pend = 1'b0; end
    end else begin
      if (ok) begin m_stg = c; m_pend = 1'b1; end
      if (m_h == m_act.hmax - 1) begin m_h = 0; m_v++; end
      else m_h++;
    end
  endtask

  task automatic tick();
    obs_t o, e;
    exp_q.push_back(model_expect());
    model_update();
    @(posedge clk);
    #1;
    cyc++;
    o = {bus.H_sync, bus.V_sync, bus.Video_on, bus.Pixel_x, bus.Pixel_y,
         bus.Frame_start, bus.Cfg_applied, bus.Cfg_error};
    e = exp_q.pop_front();
    chk(phase, 64'(o), 64'(e));
    if (bus.Cfg_applied === 1'b1) n_applied++;
    if (bus.Cfg_error === 1'b1)   n_err++;
    if (bus.H_sync === 1'b0)      n_hlow++;
    if (bus.Video_on === 1'b1)    n_vid++;
    if (bus.Frame_start === 1'b1) begin
      n_fs++;
      if (last_fs >= 0) period = cyc - last_fs;
      last_fs = cyc;
    end
  endtask

  task automatic clr();
    n_applied = 0; n_err = 0; n_fs = 0; n_hlow = 0; n_vid = 0;
    last_fs = -1; period = 0;
  endtask

  task automatic set_load(input cfg_t c);
    bus.Load_config    = 1'b1;
    bus.H_count_max    = 11'(c.hmax); bus.V_count_max    = 11'(c.vmax);
    bus.H_sync_pulse   = 8'(c.hs);    bus.V_sync_pulse   = 8'(c.vs);
    bus.H_left_margin  = 8'(c.hl);    bus.H_right_margin = 8'(c.hr);
    bus.V_left_margin  = 8'(c.vl);    bus.V_right_margin = 8'(c.vr);
  endtask

  // Parameter lines carry noise whenever the strobe is low.
  task automatic set_idle();
    bus.Load_config    = 1'b0;
    bus.H_count_max    = 11'($urandom); bus.V_count_max    = 11'($urandom);
    bus.H_sync_pulse   = 8'($urandom);  bus.V_sync_pulse   = 8'($urandom);
    bus.H_left_margin  = 8'($urandom);  bus.H_right_margin = 8'($urandom);
    bus.V_left_margin  = 8'($urandom);  bus.V_right_margin = 8'($urandom);
  endtask

  task automatic load_pulse(input cfg_t c);
    set_load(c);
    tick();
    set_idle();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_applied(input string tag, input int budget);
    int i;
    i = 0;
    while (n_applied == 0 && i < budget) begin tick(); i++; end
    if (n_applied == 0) chk({tag, "_timeout"}, 64'd0, 64'd1);
  endtask

  cfg_t c_vga, c_a, c_b, c_c, c_t, c_bad1, c_bad2, c_bad3, c_bad4;

  initial begin
    int i;
    c_vga  = '{800, 96, 48, 16, 525, 2, 33, 10};
    c_a    = '{20, 3, 2, 1, 12, 2, 2, 1};
    c_b    = '{26, 4, 3, 2, 10, 1, 1, 1};
    c_c    = '{16, 2, 1, 1, 8, 1, 2, 1};
    c_t    = '{2, 0, 0, 0, 2, 0, 0, 0};
    c_bad1 = '{100, 96, 48, 16, 525, 2, 33, 10};
    c_bad2 = '{20, 10, 8, 2, 12, 2, 2, 1};
    c_bad3 = '{1, 0, 0, 0, 12, 1, 1, 1};
    c_bad4 = '{20, 3, 2, 1, 12, 5, 4, 3};
    clr();

    set_idle();
    rst = 1'b1;
    run(3);
    rst = 1'b0;
    phase = "idle";
    run(5);

    phase = "vga";
    clr();
    load_pulse(c_vga);
    run(40 * 800);
    chk("vga_applied", 64'(n_applied), 64'd1);
    chk("vga_hsync_low", 64'(n_hlow), 64'd3840);
    chk("vga_video", 64'(n_vid), 64'd3200);
    chk("vga_frame_starts", 64'(n_fs), 64'd1);

    phase = "vga_bad";
    clr();
    load_pulse(c_bad1);
    run(900);
    chk("bad_err", 64'(n_err), 64'd1);
    chk("bad_applied", 64'(n_applied), 64'd0);

    phase = "reset2";
    rst = 1'b1;
    run(2);
    rst = 1'b0;

    phase = "cfg_a";
    clr();
    load_pulse(c_a);
    run(480);
    chk("a_period", 64'(period), 64'd240);
    clr();
    load_pulse(c_bad2); run(2);
    load_pulse(c_bad3); run(2);
    load_pulse(c_bad4); run(2);
    chk("a_bad_errs", 64'(n_err), 64'd3);
    chk("a_bad_applied", 64'(n_applied), 64'd0);

    phase = "mid_load";
    clr();
    load_pulse(c_b);
    wait_applied("mid_load", 400);
    clr();
    run(530);
    chk("b_period", 64'(period), 64'd260);
    chk("b_frame_starts", 64'(n_fs), 64'd3);

    phase = "two_loads";
    clr();
    load_pulse(c_a);
    run(5);
    load_pulse(c_c);
    wait_applied("two_loads", 400);
    run(300);
    chk("two_loads_applied", 64'(n_applied), 64'd1);
    chk("c_period", 64'(period), 64'd128);

    phase = "eof_load";
    i = 0;
    while (!at_eof() && i < 400) begin tick(); i++; end
    if (!at_eof()) chk("eof_timeout", 64'd0, 64'd1);
    clr();
    load_pulse(c_a);
    chk("eof_load_applied", 64'(n_applied), 64'd1);
    run(500);
    chk("eof_period", 64'(period), 64'd240);

    phase = "mid_reset";
    load_pulse(c_b);
    i = 0;
    while (!(m_h == 10 && m_v == 5) && i < 400) begin tick(); i++; end
    if (!(m_h == 10 && m_v == 5)) chk("mid_reset_timeout", 64'd0, 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    clr();
    run(600);
    chk("post_rst_applied", 64'(n_applied), 64'd0);
    chk("post_rst_frames", 64'(n_fs), 64'd0);
    chk("post_rst_video", 64'(n_vid), 64'd0);
    chk("post_rst_hsync", 64'(n_hlow), 64'd0);

    phase = "tiny";
    clr();
    load_pulse(c_t);
    run(10);
    chk("tiny_video", 64'(n_vid), 64'd10);
    chk("tiny_hsync", 64'(n_hlow), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
